// File: rtl/lpc_frame_packer.sv
// Packs five 16-bit encoder words per frame into 80-bit AXI-Stream beats with TLAST/TUSER framing.
// Optional frame statistics output enabled by defining PACKER_STATS_EN.
module lpc_frame_packer #(
  parameter int FRAMES_PER_PACKET = 1920,
  parameter int CNT_W             = 11
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_LAST,
  output logic [79:0] TDATA,
  output logic        TVALID,
  input  logic        TREADY,
  output logic        TLAST,
  output logic        TUSER
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0] FRAME_COUNT
`endif
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  logic [2:0]       word_idx;
  logic [79:0]      asm_reg;
  logic             hold_last;
  logic [CNT_W-1:0] pkt_cnt;
  logic             sop;
  logic             in_ready_r;

  logic [79:0]      fifo_data [2];
  logic             fifo_last [2];
  logic             fifo_user [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic [79:0]      frame_next;
  logic             accept;
  logic             complete;
  logic             pop;
  logic             space;
  logic             push;
  logic [79:0]      push_data;
  logic             push_last;

  // A new frame starts from zero so words left unfilled by IN_LAST read back as zero.
  always_comb begin
    frame_next = (word_idx == 3'd0) ? '0 : asm_reg;
    for (int k = 0; k < 5; k++)
      if (word_idx == 3'(k)) frame_next[79-16*k -: 16] = IN_DATA;
  end

  assign accept    = IN_VALID && in_ready_r && (state == FILL);
  assign complete  = accept && ((word_idx == 3'd4) || IN_LAST);
  assign pop       = (count != 2'd0) && TREADY;
  assign space     = (count != 2'd2) || pop;
  assign push      = space && (complete || (state == HOLD));
  assign push_data = (state == HOLD) ? asm_reg : frame_next;
  assign push_last = (pkt_cnt == CNT_W'(FRAMES_PER_PACKET - 1)) ||
                     ((state == HOLD) ? hold_last : IN_LAST);

  assign IN_READY = in_ready_r;
  assign TVALID   = (count != 2'd0);
  assign TDATA    = fifo_data[rd_ptr];
  assign TLAST    = fifo_last[rd_ptr];
  assign TUSER    = fifo_user[rd_ptr];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= FILL;
      word_idx   <= 3'd0;
      asm_reg    <= '0;
      hold_last  <= 1'b0;
      pkt_cnt    <= '0;
      sop        <= 1'b1;
      in_ready_r <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
        fifo_user[i] <= 1'b0;
      end
    end else begin
      case (state)
        FILL: begin
          in_ready_r <= 1'b1;
          if (accept) begin
            if (complete) begin
              word_idx <= 3'd0;
              if (!space) begin
                state      <= HOLD;
                in_ready_r <= 1'b0;
                asm_reg    <= frame_next;
                hold_last  <= IN_LAST;
              end
            end else begin
              asm_reg  <= frame_next;
              word_idx <= word_idx + 3'd1;
            end
          end
        end
        HOLD: begin
          if (space) begin
            state      <= FILL;
            in_ready_r <= 1'b1;
            word_idx   <= 3'd0;
          end
        end
        default: state <= FILL;
      endcase

      // Sideband is captured with the frame so the head entry is self-describing.
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= push_last;
        fifo_user[wr_ptr] <= sop;
        wr_ptr            <= ~wr_ptr;
        if (push_last) begin
          pkt_cnt <= '0;
          sop     <= 1'b1;
        end else begin
          pkt_cnt <= pkt_cnt + CNT_W'(1);
          sop     <= 1'b0;
        end
      end

      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) FRAME_COUNT <= '0;
    else if (pop) FRAME_COUNT <= FRAME_COUNT + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lpc_frame_packer.sv
// Self-checking bench for lpc_frame_packer against a frame-level reference model.
// Exercises FRAME_COUNT when PACKER_STATS_EN is defined.
module tb_lpc_frame_packer;

  localparam int FPP = 4;

  typedef struct packed {
    logic [79:0] d;
    logic        l;
    logic        u;
  } frame_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_LAST;
  logic [79:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;
  logic        TUSER;
`ifdef PACKER_STATS_EN
  logic [31:0] FRAME_COUNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  frame_t      exp_q[$];
  frame_t      got_q[$];
  logic [15:0] mdl_words[$];
  int          mdl_fip = 0;

  lpc_frame_packer #(.FRAMES_PER_PACKET(FPP), .CNT_W(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
    .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST), .TUSER(TUSER)
`ifdef PACKER_STATS_EN
    , .FRAME_COUNT(FRAME_COUNT)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Record every beat the sink takes; values are stable between edges here.
  always @(negedge ACLK)
    if (!ARESET && TVALID && TREADY) got_q.push_back({TDATA, TLAST, TUSER});

  function automatic void model_reset();
    exp_q.delete();
    got_q.delete();
    mdl_words.delete();
    mdl_fip = 0;
  endfunction

  // Frame-level view: a frame closes after five words or IN_LAST; packets are FPP frames or end early.
  function automatic void model_word(logic [15:0] d, logic l);
    frame_t f;
    mdl_words.push_back(d);
    if (mdl_words.size() == 5 || l) begin
      f.d = '0;
      for (int k = 0; k < mdl_words.size(); k++) f.d[79-16*k -: 16] = mdl_words[k];
      f.u = (mdl_fip == 0);
      f.l = (mdl_fip == FPP - 1) || l;
      mdl_fip = f.l ? 0 : mdl_fip + 1;
      exp_q.push_back(f);
      mdl_words.delete();
    end
  endfunction

  task automatic send_word(input logic [15:0] d, input logic l);
    int waited = 0;
    IN_DATA  = d;
    IN_LAST  = l;
    IN_VALID = 1'b1;
    @(negedge ACLK);
    while (!IN_READY && waited < 100) begin
      @(negedge ACLK);
      waited++;
    end
    if (!IN_READY) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL send_timeout: IN_READY=%b required 1", IN_READY);
    end else begin
      model_word(d, l);
    end
    @(posedge ACLK); #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge ACLK); #1;
    ARESET   = 1'b1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    model_reset();
    @(posedge ACLK); #1;
  endtask

  task automatic wait_drain(output bit timed_out);
    int cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 400) begin
      @(posedge ACLK);
      cyc++;
    end
    repeat (3) @(posedge ACLK);
    #1;
    timed_out = (got_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    ARESET = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0; TREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    n_checks++; if (TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tvalid: got %b want 0", TVALID); end
    n_checks++; if (TDATA !== 80'h0) begin n_fail++; $display("[TB] FAIL rst_tdata: got %h want 0", TDATA); end
    n_checks++; if ({TLAST, TUSER} !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_sideband: got %b want 00", {TLAST, TUSER}); end
    n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 0", IN_READY); end
    ARESET = 1'b0;
    #1;
    n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("[TB] FAIL rel_in_ready_early: got %b want 0", IN_READY); end
    @(posedge ACLK); #1;
    n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("[TB] FAIL rel_in_ready: got %b want 1", IN_READY); end
    model_reset();
  endtask

  task automatic test_single_frame();
    logic [15:0] w [5];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444; w[4] = 16'h5555;
    apply_reset();
    TREADY = 1'b1;
    for (int i = 0; i < 5; i++) send_word(w[i], 1'b0);
    n_checks++; if (TVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL single_latency: TVALID=%b want 1", TVALID); end
    n_checks++; if (TDATA !== 80'h11112222333344445555) begin n_fail++; $display("[TB] FAIL single_data: got %h want 11112222333344445555", TDATA); end
    n_checks++; if ({TUSER, TLAST} !== 2'b10) begin n_fail++; $display("[TB] FAIL single_sideband: user/last got %b want 10", {TUSER, TLAST}); end
    @(posedge ACLK); #1;
    n_checks++; if (TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL single_one_cycle: TVALID=%b want 0", TVALID); end
  endtask

  task automatic test_packet_boundaries();
    bit to;
    apply_reset();
    TREADY = 1'b1;
    for (int i = 0; i < 20; i++) send_word(16'($urandom), 1'b0);
    wait_drain(to);
    n_checks++; if (to || got_q.size() != 4) begin n_fail++; $display("[TB] FAIL pkt_count: got %0d frames want 4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].l !== (i == 3) || got_q[i].u !== (i == 0)) begin
        n_fail++;
        $display("[TB] FAIL pkt_sideband[%0d]: last/user got %b%b", i, got_q[i].l, got_q[i].u);
      end
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL pkt_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    model_reset();
    for (int i = 0; i < 20; i++) send_word(16'($urandom), 1'b0);
    wait_drain(to);
    n_checks++; if (to || got_q.size() != 4) begin n_fail++; $display("[TB] FAIL pkt2_count: got %0d frames want 4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].l !== (i == 3) || got_q[i].u !== (i == 0)) begin
        n_fail++;
        $display("[TB] FAIL pkt2_sideband[%0d]: last/user got %b%b", i, got_q[i].l, got_q[i].u);
      end
    end
  endtask

  task automatic test_in_last();
    bit to;
    apply_reset();
    TREADY = 1'b1;
    send_word(16'hAAAA, 1'b0);
    send_word(16'hBBBB, 1'b1);
    for (int i = 0; i < 5; i++) send_word(16'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) send_word(16'($urandom), i == 4);
    for (int i = 0; i < 5; i++) send_word(16'($urandom), 1'b0);
    wait_drain(to);
    n_checks++; if (to || got_q.size() != 4) begin n_fail++; $display("[TB] FAIL last_count: got %0d frames want 4", got_q.size()); end
    n_checks++; if (got_q[0].d !== 80'hAAAABBBB000000000000) begin n_fail++; $display("[TB] FAIL last_short_data: got %h want AAAABBBB000000000000", got_q[0].d); end
    n_checks++; if (got_q[0].l !== 1'b1) begin n_fail++; $display("[TB] FAIL last_short_tlast: got %b want 1", got_q[0].l); end
    n_checks++; if ({got_q[1].u, got_q[1].l} !== 2'b10) begin n_fail++; $display("[TB] FAIL last_restart: user/last got %b want 10", {got_q[1].u, got_q[1].l}); end
    n_checks++; if ({got_q[2].u, got_q[2].l} !== 2'b01) begin n_fail++; $display("[TB] FAIL last_word4: user/last got %b want 01", {got_q[2].u, got_q[2].l}); end
    n_checks++; if (got_q[3].u !== 1'b1) begin n_fail++; $display("[TB] FAIL last_word4_next_user: got %b want 1", got_q[3].u); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL last_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    frame_t first;
    apply_reset();
    TREADY = 1'b0;
    for (int i = 0; i < 15; i++) send_word(16'($urandom), 1'b0);
    first = exp_q[0];
    n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold_ready: got %b want 0", IN_READY); end
    n_checks++; if (TVALID !== 1'b1 || TDATA !== first.d) begin n_fail++; $display("[TB] FAIL bp_head: valid %b data %h want 1 %h", TVALID, TDATA, first.d); end
    repeat (6) @(posedge ACLK);
    #1;
    n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold_ready_late: got %b want 0", IN_READY); end
    n_checks++; if (TDATA !== first.d || TUSER !== first.u || TLAST !== first.l) begin n_fail++; $display("[TB] FAIL bp_frozen: got %h want %h", TDATA, first.d); end
    TREADY = 1'b1;
    wait_drain(to);
    n_checks++; if (to || got_q.size() != 3) begin n_fail++; $display("[TB] FAIL bp_count: got %0d frames want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit to;
    logic [79:0] want;
    apply_reset();
    TREADY = 1'b0;
    for (int i = 0; i < 8; i++) send_word(16'($urandom), 1'b0);
    ARESET = 1'b1;
    #1;
    n_checks++; if (TVALID !== 1'b0 || TDATA !== 80'h0) begin n_fail++; $display("[TB] FAIL mid_rst_out: valid %b data %h want 0 0", TVALID, TDATA); end
    n_checks++; if (IN_READY !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_ready: got %b want 0", IN_READY); end
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    model_reset();
    @(posedge ACLK); #1;
    TREADY = 1'b1;
    want = '0;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      want = {want[63:0], w};
      send_word(w, 1'b0);
    end
    wait_drain(to);
    n_checks++; if (to || got_q.size() != 1) begin n_fail++; $display("[TB] FAIL mid_count: got %0d frames want 1", got_q.size()); end
    n_checks++; if (got_q[0].d !== want || got_q[0].u !== 1'b1 || got_q[0].l !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_fresh: got %h u%b l%b want %h u1 l0", got_q[0].d, got_q[0].u, got_q[0].l, want);
    end
  endtask

  task automatic test_random();
    bit to;
    bit done;
    apply_reset();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge ACLK);
          #1;
          send_word(16'($urandom), ($urandom_range(0, 7) == 0));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ACLK); #1;
          TREADY = ($urandom_range(0, 2) != 0);
        end
      end
    join
    TREADY = 1'b1;
    wait_drain(to);
    n_checks++; if (to || got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rand_count: got %0d frames want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rand_frame[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef PACKER_STATS_EN
  task automatic test_stats();
    bit to;
    apply_reset();
    TREADY = 1'b1;
    for (int i = 0; i < 35; i++) send_word(16'($urandom), 1'b0);
    wait_drain(to);
    n_checks++; if (FRAME_COUNT !== 32'd7) begin n_fail++; $display("[TB] FAIL stats_count: got %0d want 7", FRAME_COUNT); end
    apply_reset();
    n_checks++; if (FRAME_COUNT !== 32'd0) begin n_fail++; $display("[TB] FAIL stats_reset: got %0d want 0", FRAME_COUNT); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_packet_boundaries();
    test_in_last();
    test_backpressure();
    test_reset_midframe();
    test_random();
`ifdef PACKER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
